// File: rtl/param_register_file.sv
// param_register_file: parametrised MIPS-style register file for the decode stage.
//   DEPTH = 2**ADDR_W entries of DATA_W bits.
//   Two combinational read ports and one synchronous write port.
//   After reset, a clear sequencer zeroes every entry, one per clock. 'ready'
//   goes high once the last entry has been cleared.
//
// Ports:
//   clk      clock; all state changes on the rising edge
//   rst      synchronous, active-high reset; restarts the clear sequence
//   RA1/RA2  read addresses          RD1/RD2  read data (combinational)
//   WA/WE/WD write address / enable / data
//   ready    clear sequence complete, writes accepted
//   wr_drop  registered one-cycle pulse: the previous cycle's write was discarded
//
// Build option:
//   RF_BYPASS_EN  when defined, a legal write in READY is forwarded to a read
//                 port that addresses the same entry in the same cycle.

// Per-port read mux: CLEAR masking, zero-register masking, optional forwarding.
module rf_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] stored,
  input  logic              byp,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);
  always_comb begin
    rd = stored;
    // Masking wins over forwarding: storage is stale or X while clearing.
    if (!ready || (ZERO_REG != 0 && ra == '0)) rd = '0;
    else if (byp)                              rd = wd;
  end
endmodule

module param_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic              WE,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              ready,
  output logic              wr_drop
);
  localparam int                NUM_RD = 2;
  localparam int                DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] mem [DEPTH];

  logic zero_hit, wr_legal;

  assign ready    = (state == READY);
  assign zero_hit = (ZERO_REG != 0) && (WA == '0);
  assign wr_legal = ready && WE && !zero_hit;

  // Next-state / counter logic. The terminal entry is compared explicitly
  // instead of relying on the counter wrapping.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == CLEAR) begin
      if (cnt == LAST) begin
        state_n = READY;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      cnt     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      // Any write not committed is a drop: during CLEAR, or to the zero register.
      wr_drop <= WE && !wr_legal;
    end
  end

  // Storage has no reset. A reset edge writes nothing, including the host write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[cnt] <= '0;
      else if (wr_legal)  mem[WA]  <= WD;
    end
  end

  logic [NUM_RD-1:0][ADDR_W-1:0] ra_v;
  logic [NUM_RD-1:0][DATA_W-1:0] stored_v, rd_v;
  logic [NUM_RD-1:0]             byp_v;

  assign ra_v = {RA2, RA1};
  assign RD1  = rd_v[0];
  assign RD2  = rd_v[1];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign stored_v[p] = mem[ra_v[p]];
`ifdef RF_BYPASS_EN
    assign byp_v[p] = wr_legal && (WA == ra_v[p]);
`else
    assign byp_v[p] = 1'b0;
`endif
    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .ready (ready),
      .ra    (ra_v[p]),
      .stored(stored_v[p]),
      .byp   (byp_v[p]),
      .wd    (WD),
      .rd    (rd_v[p])
    );
  end
endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file. Two instances share the stimulus:
// uz with ZERO_REG=1 and un with ZERO_REG=0. Expected values are queued as the
// stimulus is applied and are popped when the outputs are sampled.
module tb_param_register_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  RA1, RA2, WA;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] z_rd1, z_rd2, n_rd1, n_rd2;
  logic        z_ready, n_ready, z_drop, n_drop;

  int checks = 0;
  int errors = 0;

  typedef struct {string tag; logic [31:0] val;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  param_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) uz (
    .clk(clk), .rst(rst), .RA1(RA1), .RA2(RA2), .WA(WA), .WE(WE), .WD(WD),
    .RD1(z_rd1), .RD2(z_rd2), .ready(z_ready), .wr_drop(z_drop));

  param_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) un (
    .clk(clk), .rst(rst), .RA1(RA1), .RA2(RA2), .WA(WA), .WE(WE), .WD(WD),
    .RD1(n_rd1), .RD2(n_rd2), .ready(n_ready), .wr_drop(n_drop));

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed %h expected <queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Inputs change 1 time unit after the rising edge, well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected ready / wr_drop for both instances during the CLEAR sequence.
  task automatic chk_status(input logic exp_ready, input logic exp_drop);
    expect_v("z_ready", {31'b0, exp_ready}); chk({31'b0, z_ready});
    expect_v("n_ready", {31'b0, exp_ready}); chk({31'b0, n_ready});
    expect_v("z_drop",  {31'b0, exp_drop});  chk({31'b0, z_drop});
    expect_v("n_drop",  {31'b0, exp_drop});  chk({31'b0, n_drop});
  endtask

  // Expect identical read data from both instances on both ports.
  task automatic chk_rd_all(input string tag, input logic [31:0] v);
    expect_v({tag, "_z1"}, v); chk(z_rd1);
    expect_v({tag, "_z2"}, v); chk(z_rd2);
    expect_v({tag, "_n1"}, v); chk(n_rd1);
    expect_v({tag, "_n2"}, v); chk(n_rd2);
  endtask

  logic [31:0] byp_exp;

  initial begin
    rst = 1'b1; RA1 = '0; RA2 = '0; WA = '0; WE = 1'b0; WD = '0;
    tick(); tick();
    chk_status(1'b0, 1'b0);

    // Clear sequence. One write is attempted on edge 4; ready must rise on edge 32.
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      RA1 = 5'(i); RA2 = 5'(31 - i);
      WE = (i == 4); WA = 5'd3; WD = 32'h55;
      #1;
      if (i < 32) chk_rd_all("clr_rd", 32'h0);
      tick();
      WE = 1'b0;
      chk_status(i == 32, i == 4);
    end

    // Every entry reads zero after the clear.
    for (int a = 0; a < 32; a++) begin
      RA1 = 5'(a); RA2 = 5'(31 - a);
      #1;
      chk_rd_all("post_clr", 32'h0);
    end

    // Normal write, then read it on both ports.
    WE = 1'b1; WA = 5'd5; WD = 32'hDEADBEEF; RA1 = 5'd5; RA2 = 5'd5;
    tick();
    WE = 1'b0;
    #1;
    chk_rd_all("wr5", 32'hDEADBEEF);

    // Write to the top entry.
    WE = 1'b1; WA = 5'd31; WD = 32'h1;
    tick();
    WE = 1'b0; RA1 = 5'd31;
    #1;
    expect_v("wr31_z", 32'h1); chk(z_rd1);
    expect_v("wr31_n", 32'h1); chk(n_rd1);

    // Entry 0. Forwarding applies only to the ordinary-register instance.
    WE = 1'b1; WA = 5'd0; WD = 32'hFFFFFFFF; RA1 = 5'd0;
    #1;
`ifdef RF_BYPASS_EN
    byp_exp = 32'hFFFFFFFF;
`else
    byp_exp = 32'h0;
`endif
    expect_v("r0_pre_z", 32'h0);   chk(z_rd1);
    expect_v("r0_pre_n", byp_exp); chk(n_rd1);
    tick();
    WE = 1'b0;
    #1;
    expect_v("r0_z_rd",   32'h0);        chk(z_rd1);
    expect_v("r0_n_rd",   32'hFFFFFFFF); chk(n_rd1);
    expect_v("r0_z_drop", 32'h1);        chk({31'b0, z_drop});
    expect_v("r0_n_drop", 32'h0);        chk({31'b0, n_drop});
    tick();
    expect_v("r0_z_drop_end", 32'h0); chk({31'b0, z_drop});

    // Same-cycle forwarding on port 2.
    WE = 1'b1; WA = 5'd9; WD = 32'hA5A5A5A5; RA2 = 5'd9;
    #1;
`ifdef RF_BYPASS_EN
    byp_exp = 32'hA5A5A5A5;
`else
    byp_exp = 32'h0;
`endif
    expect_v("byp_pre_z", byp_exp); chk(z_rd2);
    expect_v("byp_pre_n", byp_exp); chk(n_rd2);
    tick();
    WE = 1'b0;
    #1;
    expect_v("byp_post_z", 32'hA5A5A5A5); chk(z_rd2);
    expect_v("byp_post_n", 32'hA5A5A5A5); chk(n_rd2);

    // Reset in the middle of operation. The write to entry 0 on the reset
    // edge must not pulse wr_drop.
    WE = 1'b1; WA = 5'd7; WD = 32'h1234;
    tick();
    rst = 1'b1; WE = 1'b1; WA = 5'd0; WD = 32'h77;
    tick();
    WE = 1'b0;
    chk_status(1'b0, 1'b0);

    // Reset again at clear cycle 10. The count must restart from zero.
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_status(1'b0, 1'b0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk_status(i == 32, 1'b0);
    end

    RA1 = 5'd7; RA2 = 5'd5;
    #1;
    chk_rd_all("rst_cleared", 32'h0);
    RA1 = 5'd9; RA2 = 5'd31;
    #1;
    chk_rd_all("rst_cleared2", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
